// File: rtl/vdp1_pkg.sv
// rtl/vdp1_pkg.sv - shared VDP1 constants and the Gouraud interpolator FSM state type
// Contents: GOUR_INT_W / GOUR_FRAC_W default widths, gour_state_t (IDLE, DIV, RUN).
package vdp1_pkg;

  localparam int GOUR_INT_W  = 5;
  localparam int GOUR_FRAC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RUN  = 2'd2
  } gour_state_t;

endpackage

// File: rtl/vdp1_gouraud_interp_if.sv
// rtl/vdp1_gouraud_interp_if.sv - span request / pixel stream bundle of the Gouraud interpolator
// Signals: start_valid/start_ready/c_start/c_end/len/abort (span request side),
//          pix_valid/pix_ready/pix_c/pix_last (pixel stream side), busy (status).
// Modports: master = span issuer and pixel consumer, slave = interpolator.
interface vdp1_gouraud_interp_if #(
  parameter int NCH   = 3,
  parameter int INT_W = vdp1_pkg::GOUR_INT_W,
  parameter int LEN_W = 10
);

  logic                   start_valid;
  logic                   start_ready;
  logic [NCH*INT_W-1:0]   c_start;
  logic [NCH*INT_W-1:0]   c_end;
  logic [LEN_W-1:0]       len;
  logic                   abort;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [NCH*INT_W-1:0]   pix_c;
  logic                   pix_last;
  logic                   busy;

  modport master (
    output start_valid, c_start, c_end, len, abort, pix_ready,
    input  start_ready, pix_valid, pix_c, pix_last, busy
  );

  modport slave (
    input  start_valid, c_start, c_end, len, abort, pix_ready,
    output start_ready, pix_valid, pix_c, pix_last, busy
  );

endinterface

// File: rtl/vdp1_serdiv.sv
// rtl/vdp1_serdiv.sv - restoring serial divider, one quotient bit per cycle
// Ports: clk, rst (async, active-high), start (load operands), dividend, divisor,
//        quotient (valid while done), done (high once DVD_W iterations have run).
module vdp1_serdiv #(
  parameter int DVD_W = 17,
  parameter int DVS_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] rem;
  logic [DVD_W-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   diff;

  // Dividend bits are shifted out of the top of quo while quotient bits enter at the bottom.
  // The remainder is always below the divisor, so one extra bit holds the shifted value and
  // the top bit of the trial subtraction tells whether the divisor fits.
  assign rem_sh = {rem, quo[DVD_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      dvs    <= divisor;
      rem    <= '0;
      quo    <= dividend;
      cnt    <= CW'(DVD_W);
      active <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (!diff[DVS_W]) begin
        rem <= diff[DVS_W-1:0];
        quo <= {quo[DVD_W-2:0], 1'b1};
      end else begin
        rem <= rem_sh[DVS_W-1:0];
        quo <= {quo[DVD_W-2:0], 1'b0};
      end
    end
  end

  assign quotient = quo;
  assign done     = active && (cnt == '0);

endmodule

// File: rtl/vdp1_gouraud_interp.sv
// rtl/vdp1_gouraud_interp.sv - Gouraud colour interpolator: emits N+1 pixels stepping C_START to C_END
// Ports: clk, rst (async, active-high), bus (slave modport of vdp1_gouraud_interp_if):
//        span request with abort, pixel stream with last marker, busy status.
module vdp1_gouraud_interp
  import vdp1_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int INT_W  = GOUR_INT_W,
  parameter int FRAC_W = GOUR_FRAC_W,
  parameter int LEN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  vdp1_gouraud_interp_if.slave  bus
);

  localparam int Q = INT_W + FRAC_W;

  gour_state_t          state, state_next;
  logic                 accept;
  logic                 div_start;
  logic                 div_ok;
  logic                 fire;
  logic                 last;
  logic [NCH-1:0]       div_done;
  logic [NCH*INT_W-1:0] pix_c_w;
  logic [LEN_W-1:0]     k;
  logic [LEN_W-1:0]     len_q;

  assign accept    = bus.start_valid && (state == ST_IDLE);
  assign div_start = accept && (bus.len != '0);
  assign div_ok    = &div_done;
  assign last      = (state == ST_RUN) && (k == len_q);
  // Abort takes priority over a pixel handshake in the same cycle.
  assign fire      = (state == ST_RUN) && bus.pix_ready && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.start_valid) begin
          state_next = (bus.len == '0) ? ST_RUN : ST_DIV;
        end
      end
      ST_DIV: begin
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else if (div_ok) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else if (bus.pix_ready && last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      len_q <= '0;
    end else if (accept) begin
      k     <= '0;
      len_q <= bus.len;
    end else if (fire) begin
      k <= k + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [INT_W-1:0] cs;
    logic [INT_W-1:0] ce;
    logic [INT_W-1:0] mag;
    logic [INT_W-1:0] ce_q;
    logic             dir;
    logic [Q-1:0]     acc;
    logic [Q-1:0]     step;

    assign cs  = bus.c_start[i*INT_W +: INT_W];
    assign ce  = bus.c_end[i*INT_W +: INT_W];
    assign mag = (ce < cs) ? (cs - ce) : (ce - cs);

    // The quotient register stays stable after done, so it serves as the step for the whole span.
    vdp1_serdiv #(
      .DVD_W (Q),
      .DVS_W (LEN_W)
    ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend ({mag, {FRAC_W{1'b0}}}),
      .divisor  (bus.len),
      .quotient (step),
      .done     (div_done[i])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc  <= '0;
        dir  <= 1'b0;
        ce_q <= '0;
      end else if (accept) begin
        acc  <= {cs, {FRAC_W{1'b0}}};
        dir  <= (ce < cs);
        ce_q <= ce;
      end else if (fire) begin
        acc <= dir ? (acc - step) : (acc + step);
      end
    end

    // The final pixel is forced to the exact end colour to hide truncation error in the step;
    // a zero-length span has no end pixel distinct from its start, so it shows the start colour.
    assign pix_c_w[i*INT_W +: INT_W] = (state != ST_RUN)          ? '0   :
                                       (last && (len_q != '0))    ? ce_q :
                                                                    acc[Q-1 -: INT_W];
  end

  assign bus.start_ready = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.pix_valid   = (state == ST_RUN);
  assign bus.pix_last    = last;
  assign bus.pix_c       = pix_c_w;

endmodule

// File: tb/tb_vdp1_gouraud_interp.sv
// tb/tb_vdp1_gouraud_interp.sv - directed self-checking bench for vdp1_gouraud_interp
module tb_vdp1_gouraud_interp;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [14:0] obs [0:63];

  vdp1_gouraud_interp_if #(.NCH(3), .INT_W(5), .LEN_W(10)) bus ();

  vdp1_gouraud_interp #(
    .NCH    (3),
    .INT_W  (5),
    .FRAC_W (12),
    .LEN_W  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_ch(input int s, input int e, input int n, input int k);
    int mag;
    int step;
    if (k == n) return (n == 0) ? s : e;
    mag  = (e > s) ? (e - s) : (s - e);
    step = (mag * 4096) / n;
    if (e >= s) return s + (k * step) / 4096;
    return s - (k * step + 4095) / 4096;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_valid"}, bus.pix_valid, 0);
    check({tag, "_pix_last"},  bus.pix_last,  0);
    check({tag, "_pix_c"},     bus.pix_c,     0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_start_rdy"}, bus.start_ready, 1);
  endtask

  // abort_div: latency-cycle index at which ABORT is raised during DIV (-1 none).
  // stop_k: pixel index at which the span is cut by ABORT or by RST (use_rst) (-1 none).
  task automatic run_span(input logic [14:0] s, input logic [14:0] e, input int n, input bit rnd,
                          input int abort_div, input int stop_k, input bit use_rst);
    int lat;
    int k;
    int guard;
    logic [14:0] held;
    logic held_last;
    @(negedge clk);
    check("req_start_ready", bus.start_ready, 1);
    bus.c_start = s;
    bus.c_end = e;
    bus.len = 10'(n);
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    check("accept_busy", bus.busy, 1);
    lat = 0;
    while (!bus.pix_valid && lat < 100) begin
      if (lat == abort_div) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("div_abort_valid", bus.pix_valid, 0);
        check("div_abort_idle", bus.start_ready, 1);
        check("div_abort_busy", bus.busy, 0);
        return;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (n == 0) ? 0 : 18);
    if (!bus.pix_valid) return;
    k = 0;
    guard = 0;
    while (k <= n && guard < 1000) begin
      guard++;
      if (k == stop_k) begin
        if (use_rst) begin
          #2 rst = 1'b1;
          #1 check_reset_outputs("async_rst");
          @(negedge clk);
          rst = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("post_rst_no_pix", bus.pix_valid, 0);
          end
        end else begin
          bus.abort = 1'b1;
          bus.pix_ready = 1'b1;
          @(negedge clk);
          bus.abort = 1'b0;
          bus.pix_ready = 1'b0;
          check("run_abort_valid", bus.pix_valid, 0);
          check("run_abort_idle", bus.start_ready, 1);
        end
        return;
      end
      if (rnd && $urandom_range(0, 2) == 0) begin
        held = bus.pix_c;
        held_last = bus.pix_last;
        bus.pix_ready = 1'b0;
        @(negedge clk);
        check("stall_pix_c", bus.pix_c, held);
        check("stall_last", bus.pix_last, held_last);
        check("stall_valid", bus.pix_valid, 1);
      end else begin
        check($sformatf("pix%0d_valid", k), bus.pix_valid, 1);
        for (int c = 0; c < 3; c++) begin
          check($sformatf("pix%0d_ch%0d", k, c), bus.pix_c[c*5 +: 5],
                exp_ch(int'(s[c*5 +: 5]), int'(e[c*5 +: 5]), n, k));
        end
        check($sformatf("pix%0d_last", k), bus.pix_last, (k == n));
        obs[k] = bus.pix_c;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.pix_ready = 1'b0;
        k++;
      end
    end
    check("pix_count", k, n + 1);
    check("end_valid", bus.pix_valid, 0);
    check("end_idle", bus.start_ready, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.c_start = '0;
    bus.c_end = '0;
    bus.len = '0;
    bus.abort = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // R 0->31, G 0->16, B 0->0 over 31 steps
    run_span({5'd0, 5'd0, 5'd0}, {5'd0, 5'd16, 5'd31}, 31, 1'b0, -1, -1, 1'b0);
    check("hand_r_pix17", obs[17][4:0], 17);
    check("hand_g_pix1", obs[1][9:5], 0);
    check("hand_g_pix2", obs[2][9:5], 1);
    check("hand_g_pix31", obs[31][9:5], 16);
    check("hand_b_pix20", obs[20][14:10], 0);

    run_span({5'd31, 5'd31, 5'd31}, 15'd0, 1, 1'b0, -1, -1, 1'b0);
    check("hand_down_pix0", obs[0], 15'h7fff);
    check("hand_down_pix1", obs[1], 15'h0000);

    run_span({5'd9, 5'd8, 5'd7}, {5'd3, 5'd2, 5'd1}, 0, 1'b0, -1, -1, 1'b0);
    check("hand_len0_pix0", obs[0], {5'd9, 5'd8, 5'd7});

    // ABORT while idle must be ignored
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_ready", bus.start_ready, 1);

    run_span({5'd10, 5'd20, 5'd3}, {5'd10, 5'd2, 5'd29}, 4, 1'b1, -1, -1, 1'b0);
    run_span({5'd0, 5'd5, 5'd30}, {5'd31, 5'd25, 5'd1}, 7, 1'b1, -1, -1, 1'b0);

    run_span({5'd1, 5'd2, 5'd3}, {5'd20, 5'd21, 5'd22}, 5, 1'b0, 5, -1, 1'b0);
    run_span({5'd4, 5'd5, 5'd6}, {5'd16, 5'd17, 5'd18}, 3, 1'b0, -1, -1, 1'b0);

    run_span({5'd30, 5'd0, 5'd15}, {5'd0, 5'd30, 5'd15}, 6, 1'b0, -1, 2, 1'b0);
    run_span({5'd2, 5'd4, 5'd8}, {5'd8, 5'd4, 5'd2}, 2, 1'b0, -1, -1, 1'b0);

    run_span({5'd5, 5'd5, 5'd5}, {5'd25, 5'd25, 5'd25}, 8, 1'b0, -1, 3, 1'b1);
    run_span({5'd25, 5'd12, 5'd0}, {5'd1, 5'd13, 5'd31}, 10, 1'b0, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
